// File: rtl/gain_div_scheduler_pkg.sv
// gain_div_scheduler_pkg: channel state encoding and default widths for the AGC divider scheduler.
package gain_div_scheduler_pkg;
  localparam int DEF_N_CHANNELS = 4;
  localparam int DEF_AMPLITUDE_DATA_SIZE = 13;
  localparam int DEF_RESULT_DATA_SIZE = 14;
  localparam int DIV_RESULT_DATA_SIZE = 24;
  localparam int TAG_W = $clog2(DEF_N_CHANNELS);
  typedef enum logic [1:0] {
    CH_IDLE     = 2'd0,
    CH_PENDING  = 2'd1,
    CH_INFLIGHT = 2'd2
  } ch_state_e;
endpackage

// File: rtl/gain_div_scheduler_if.sv
// gain_div_scheduler_if: operand/quotient bus between the scheduler and the shared div_gen.
interface gain_div_scheduler_if #(
  parameter int A  = 13,
  parameter int DR = 24
);
  logic          div_valid;
  logic [A-1:0]  dividend;
  logic [A-1:0]  divisor;
  logic          dout_valid;
  logic [DR-1:0] dout;
  modport master (output div_valid, dividend, divisor, input dout_valid, dout);
  modport slave  (input div_valid, dividend, divisor, output dout_valid, dout);
endinterface

// File: rtl/gain_div_scheduler_rr_arbiter.sv
// gain_div_scheduler_rr_arbiter: first requester at or after ptr wins, pointer advances past the winner.
module gain_div_scheduler_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o,
  output logic [$clog2(N)-1:0] next_ptr_o
);
  localparam int TW = $clog2(N);
  logic [TW-1:0] k;
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = TW'((int'(ptr_i) + i) % N);
      if (req_i[k]) begin
        idx_o = k;
        any_o = 1'b1;
      end
    end
    grant_o = '0;
    grant_o[idx_o] = any_o;
    next_ptr_o = (int'(idx_o) == N - 1) ? '0 : idx_o + TW'(1);
  end
endmodule

// File: rtl/gain_div_scheduler.sv
// gain_div_scheduler: shares one pipelined divider between AGC channels, routing quotients back by tag.
module gain_div_scheduler
  import gain_div_scheduler_pkg::*;
#(
  parameter int N_CHANNELS           = DEF_N_CHANNELS,
  parameter int AMPLITUDE_DATA_SIZE  = DEF_AMPLITUDE_DATA_SIZE,
  parameter int RESULT_DATA_SIZE     = DEF_RESULT_DATA_SIZE,
  parameter int DIV_RESULT_DATA_SIZE = gain_div_scheduler_pkg::DIV_RESULT_DATA_SIZE,
  parameter int DIV_LATENCY          = 1
) (
  input  logic                                      i_clock,
  input  logic                                      i_reset_n,
  input  logic                                      i_enable,
  input  logic [N_CHANNELS-1:0]                     i_req,
  input  logic [N_CHANNELS*AMPLITUDE_DATA_SIZE-1:0] i_reference,
  input  logic [N_CHANNELS*AMPLITUDE_DATA_SIZE-1:0] i_error,
  output logic [N_CHANNELS-1:0]                     o_ack,
  output logic [N_CHANNELS*RESULT_DATA_SIZE-1:0]    o_result,
  output logic [N_CHANNELS-1:0]                     o_result_valid,
  output logic [N_CHANNELS-1:0]                     o_div_by_zero,
  gain_div_scheduler_if.master                      div,
  output logic                                      o_busy,
  output logic                                      o_protocol_error
);
  localparam int N  = N_CHANNELS;
  localparam int A  = AMPLITUDE_DATA_SIZE;
  localparam int R  = RESULT_DATA_SIZE;
  localparam int DR = DIV_RESULT_DATA_SIZE;
  localparam int L  = DIV_LATENCY;
  localparam int TW = $clog2(N);
  ch_state_e     st_q [N];
  logic [A-1:0]  ref_q [N];
  logic [A-1:0]  err_q [N];
  logic [R-1:0]  res_q [N];
  logic [TW-1:0] rr_q, rr_d, gnt_idx, itag_q, head_t;
  logic [N-1:0]  pend, gnt, ack_q, rv_q, dz_q;
  logic          gnt_any, zero_issue, dv_q, perr_q, head_v;
  logic [A-1:0]  dd_q, ds_q;
  logic          pv_q [L];
  logic [TW-1:0] pt_q [L];
  logic [1:0]    zv_q;
  logic [TW-1:0] zt_q [2];
  gain_div_scheduler_rr_arbiter #(.N(N)) u_arb (
    .req_i      (pend & {N{i_enable}}),
    .ptr_i      (rr_q),
    .grant_o    (gnt),
    .idx_o      (gnt_idx),
    .any_o      (gnt_any),
    .next_ptr_o (rr_d)
  );
  always_comb begin
    pend = '0;
    o_result = '0;
    o_busy = 1'b0;
    for (int k = 0; k < N; k++) begin
      pend[k] = st_q[k] == CH_PENDING;
      o_result[k*R +: R] = res_q[k];
      o_busy = o_busy | (st_q[k] != CH_IDLE);
    end
    zero_issue = gnt_any && ref_q[gnt_idx] == '0;
    head_v = pv_q[L-1];
    head_t = pt_q[L-1];
  end
  assign o_ack            = ack_q;
  assign o_result_valid   = rv_q;
  assign o_div_by_zero    = dz_q;
  assign o_protocol_error = perr_q;
  assign div.div_valid    = dv_q;
  assign div.dividend     = dd_q;
  assign div.divisor      = ds_q;
  if (DR > R) begin : g_unused
    logic unused_dout;
    assign unused_dout = ^div.dout[DR-1:R];
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int k = 0; k < N; k++) begin
        st_q[k] <= CH_IDLE;
        ref_q[k] <= '0;
        err_q[k] <= '0;
        res_q[k] <= '0;
      end
      for (int j = 0; j < L; j++) begin
        pv_q[j] <= 1'b0;
        pt_q[j] <= '0;
      end
      rr_q <= '0;
      itag_q <= '0;
      dv_q <= 1'b0;
      dd_q <= '0;
      ds_q <= '0;
      zv_q <= '0;
      zt_q[0] <= '0;
      zt_q[1] <= '0;
      ack_q <= '0;
      rv_q <= '0;
      dz_q <= '0;
      perr_q <= 1'b0;
    end else begin
      ack_q <= '0;
      rv_q <= '0;
      dv_q <= gnt_any && !zero_issue;
      dd_q <= err_q[gnt_idx];
      ds_q <= ref_q[gnt_idx];
      itag_q <= gnt_idx;
      // zero divisors ride a fixed 2-stage side pipe instead of the divider
      zv_q <= {zv_q[0], zero_issue};
      zt_q[0] <= gnt_idx;
      zt_q[1] <= zt_q[0];
      pv_q[0] <= dv_q;
      pt_q[0] <= itag_q;
      for (int j = 1; j < L; j++) begin
        pv_q[j] <= pv_q[j-1];
        pt_q[j] <= pt_q[j-1];
      end
      if (gnt_any) rr_q <= rr_d;
      for (int k = 0; k < N; k++) begin
        if (st_q[k] == CH_IDLE && i_req[k]) begin
          ref_q[k] <= i_reference[k*A +: A];
          err_q[k] <= i_error[k*A +: A];
          ack_q[k] <= 1'b1;
          st_q[k] <= CH_PENDING;
        end
        if (gnt[k]) st_q[k] <= CH_INFLIGHT;
      end
      if (zv_q[1]) begin
        res_q[zt_q[1]] <= '1;
        dz_q[zt_q[1]] <= 1'b1;
        rv_q[zt_q[1]] <= 1'b1;
        st_q[zt_q[1]] <= CH_IDLE;
      end
      if (head_v) begin
        st_q[head_t] <= CH_IDLE;
        if (div.dout_valid) begin
          res_q[head_t] <= div.dout[R-1:0];
          dz_q[head_t] <= 1'b0;
          rv_q[head_t] <= 1'b1;
        end
      end
      if (div.dout_valid != head_v) perr_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gain_div_scheduler.sv
// tb_gain_div_scheduler: directed checks of the divider scheduler against a delayed-quotient div_gen model.
module tb_gain_div_scheduler;
  parameter int DIV_LATENCY = 1;
  localparam int N = 4, A = 13, R = 14, DR = 24, L = DIV_LATENCY;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, inj = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*A-1:0] refs = '0, errs = '0;
  logic [N-1:0] ack, rv, dz;
  logic [N*R-1:0] res;
  logic busy, perr;
  logic mv [L] = '{default: 1'b0};
  logic [DR-1:0] mq [L] = '{default: '0};
  int compared = 0, mismatched = 0;
  int dv_exp [4] = '{11, 3, 7, 5};
  logic [3:0] rv_ord [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
  gain_div_scheduler_if #(.A(A), .DR(DR)) dif ();
  gain_div_scheduler #(.DIV_LATENCY(DIV_LATENCY)) dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_enable         (en),
    .i_req            (req),
    .i_reference      (refs),
    .i_error          (errs),
    .o_ack            (ack),
    .o_result         (res),
    .o_result_valid   (rv),
    .o_div_by_zero    (dz),
    .div              (dif),
    .o_busy           (busy),
    .o_protocol_error (perr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    mv[0] <= dif.div_valid;
    mq[0] <= (dif.divisor == '0) ? '1 : DR'(dif.dividend) / DR'(dif.divisor);
    for (int j = 1; j < L; j++) begin
      mv[j] <= mv[j-1];
      mq[j] <= mq[j-1];
    end
  end
  assign dif.dout_valid = mv[L-1] | inj;
  assign dif.dout = mq[L-1];
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_op(input int k, input int e, input int r);
    errs[k*A +: A] = A'(e);
    refs[k*A +: A] = A'(r);
  endtask
  function automatic logic [31:0] rs(input int k);
    return 32'(res[k*R +: R]);
  endfunction
  initial begin
    tick(2);
    chk("rst_result", 32'(res), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_perr", 32'(perr), 0);
    chk("rst_ack_rv_dz", {20'd0, ack, rv, dz}, 0);
    chk("rst_div_valid", 32'(dif.div_valid), 0);
    rst_n = 1'b1;
    en = 1'b1;
    // single divide on ch0
    set_op(0, 1000, 500);
    req = 4'b0001;
    tick(1);
    chk("single_ack", 32'(ack), 4'b0001);
    req = '0;
    tick(1);
    chk("single_dv", 32'(dif.div_valid), 1);
    chk("single_dividend", 32'(dif.dividend), 1000);
    chk("single_divisor", 32'(dif.divisor), 500);
    chk("single_busy", 32'(busy), 1);
    for (int c = 2; c <= 2 + L; c++) begin
      tick(1);
      chk("single_rv", 32'(rv), (c == 2 + L) ? 4'b0001 : 4'b0000);
    end
    chk("single_res0", rs(0), 2);
    chk("single_dz", 32'(dz), 0);
    // zero divisor on ch1
    set_op(1, 77, 0);
    req = 4'b0010;
    tick(1);
    chk("zero_ack", 32'(ack), 4'b0010);
    req = '0;
    tick(1);
    chk("zero_no_dv", 32'(dif.div_valid), 0);
    tick(1);
    chk("zero_rv_early", 32'(rv), 0);
    tick(1);
    chk("zero_rv", 32'(rv), 4'b0010);
    chk("zero_res1", rs(1), 14'h3FFF);
    chk("zero_dz", 32'(dz), 4'b0010);
    // contention, rr pointer now at 2
    set_op(0, 100, 7);
    set_op(1, 200, 5);
    set_op(2, 300, 11);
    set_op(3, 4000, 3);
    req = 4'b1111;
    tick(1);
    chk("cont_ack", 32'(ack), 4'b1111);
    req = '0;
    for (int c = 1; c <= 5 + L; c++) begin
      tick(1);
      if (c <= 4) begin
        chk("cont_dv", 32'(dif.div_valid), 1);
        chk("cont_divisor", 32'(dif.divisor), 32'(dv_exp[c-1]));
      end
      chk("cont_rv", 32'(rv), (c >= 2 + L && c <= 5 + L) ? 32'(rv_ord[c-2-L]) : 0);
      if (c == 4 + L) chk("cont_dz_held", 32'(dz), 4'b0010);
    end
    chk("cont_res0", rs(0), 14);
    chk("cont_res1", rs(1), 40);
    chk("cont_res2", rs(2), 27);
    chk("cont_res3", rs(3), 1333);
    chk("cont_dz_clear", 32'(dz), 0);
    // enable gate on ch3
    en = 1'b0;
    set_op(3, 900, 30);
    req = 4'b1000;
    tick(1);
    chk("gate_ack", 32'(ack), 4'b1000);
    req = '0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      chk("gate_no_dv", 32'(dif.div_valid), 0);
      chk("gate_busy", 32'(busy), 1);
    end
    en = 1'b1;
    tick(1);
    chk("gate_dv", 32'(dif.div_valid), 1);
    chk("gate_divisor", 32'(dif.divisor), 30);
    tick(1 + L);
    chk("gate_rv", 32'(rv), 4'b1000);
    chk("gate_res3", rs(3), 30);
    tick(1);
    chk("gate_idle", 32'(busy), 0);
    chk("pre_perr", 32'(perr), 0);
    // spurious divider valid
    inj = 1'b1;
    tick(1);
    inj = 1'b0;
    chk("perr_set", 32'(perr), 1);
    tick(3);
    chk("perr_sticky", 32'(perr), 1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("perr_rst", 32'(perr), 0);
    chk("perr_rst_res", 32'(res), 0);
    chk("perr_rst_dz", 32'(dz), 0);
    // reset with two divides in flight
    set_op(0, 50, 5);
    set_op(1, 60, 6);
    req = 4'b0011;
    tick(1);
    chk("mid_ack", 32'(ack), 4'b0011);
    req = '0;
    tick(2);
    chk("mid_dv", 32'(dif.div_valid), 1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("mid_busy", 32'(busy), 0);
    for (int c = 0; c < L + 2; c++) begin
      tick(1);
      chk("mid_no_rv", 32'(rv), 0);
    end
    chk("mid_busy_end", 32'(busy), 0);
    chk("mid_late_perr", 32'(perr), 1);
    chk("mid_res", 32'(res), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
